// File: rtl/bcd_time_counter_pkg.sv
// Shared limits, FSM encoding and BCD helpers
// for the time-of-day counter.
package bcd_time_counter_pkg;

   localparam logic [7:0] SEC_MAX      = 8'h59;
   localparam logic [7:0] MIN_MAX      = 8'h59;
   localparam int         HOUR_MOD_DEF = 24;

   typedef enum logic {
      RUN   = 1'b0,
      APPLY = 1'b1
   } state_e;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic bcd_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, 00..MOD-1, with load
// and a carry that fires on the wrap increment.
module bcd_mod_counter
   import bcd_time_counter_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic       clk_input,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] val,
   output logic       carry_out
);

   localparam logic [7:0] MAX = to_bcd(MOD - 1);

   logic [7:0] val_q, val_d;

   always_comb begin
      val_d     = val_q;
      carry_out = 1'b0;
      if (load) begin
         val_d = load_val;
      end else if (inc) begin
         if (val_q == MAX) begin
            val_d     = 8'h00;
            carry_out = 1'b1;
         end else if (val_q[3:0] == 4'd9) begin
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         end else begin
            val_d = {val_q[7:4], val_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk_input or negedge rst_n) begin
      if (!rst_n) val_q <= 8'h00;
      else        val_q <= val_d;
   end

   assign val = val_q;

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day core: synchronised 1 Hz tick, BCD
// hh:mm:ss chain and a handshaked time-set path.
module bcd_time_counter
   import bcd_time_counter_pkg::*;
#(
   parameter int HOUR_MOD    = HOUR_MOD_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_input,
   input  logic       rst_n,
   input  logic       tick_in,
   input  logic       en,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [7:0] set_hour,
   input  logic [7:0] set_min,
   input  logic [7:0] set_sec,
   output logic       set_err,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       sec_pulse,
   output logic       day_wrap
);

   localparam logic [7:0] HOUR_LIM = to_bcd(HOUR_MOD);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, rise_d, rise_q;
   state_e                 state_q, state_d;
   logic                   ready_q;
   logic                   pending_q, pending_d;
   logic [7:0]             hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
   logic                   set_err_q, set_err_d;
   logic                   sec_pulse_q, day_wrap_q;
   logic                   accept, range_ok, inc, load;
   logic                   sec_c, min_c, hour_c;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = tick_in;
   end

   assign rise_d = sync_q[SYNC_STAGES-1] & ~edge_q;

   assign set_ready = ready_q & (state_q == RUN);
   assign accept    = set_valid & set_ready;

   assign range_ok = bcd_ok(hr_q) && bcd_ok(mn_q) && bcd_ok(sc_q)
                  && (sc_q <= SEC_MAX) && (mn_q <= MIN_MAX)
                  && (hr_q < HOUR_LIM);

   // Ticks arriving while a load is in flight are held in pending_q
   // and applied on the first RUN cycle, on top of the loaded time.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      hr_d      = hr_q;
      mn_d      = mn_q;
      sc_d      = sc_q;
      set_err_d = 1'b0;
      inc       = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         RUN: begin
            if (accept) begin
               state_d   = APPLY;
               hr_d      = set_hour;
               mn_d      = set_min;
               sc_d      = set_sec;
               pending_d = en & (pending_q | rise_q);
            end else begin
               inc       = en & (rise_q | pending_q);
               pending_d = en & rise_q & pending_q;
            end
         end
         APPLY: begin
            state_d   = RUN;
            pending_d = en & (pending_q | rise_q);
            load      = range_ok;
            set_err_d = ~range_ok;
         end
      endcase
   end

   always_ff @(posedge clk_input or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         edge_q      <= 1'b0;
         rise_q      <= 1'b0;
         state_q     <= RUN;
         ready_q     <= 1'b0;
         pending_q   <= 1'b0;
         hr_q        <= 8'h00;
         mn_q        <= 8'h00;
         sc_q        <= 8'h00;
         set_err_q   <= 1'b0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         edge_q      <= sync_q[SYNC_STAGES-1];
         rise_q      <= rise_d;
         state_q     <= state_d;
         ready_q     <= 1'b1;
         pending_q   <= pending_d;
         hr_q        <= hr_d;
         mn_q        <= mn_d;
         sc_q        <= sc_d;
         set_err_q   <= set_err_d;
         sec_pulse_q <= inc;
         day_wrap_q  <= hour_c;
      end
   end

   bcd_mod_counter #(.MOD(60)) u_sec (
      .clk_input (clk_input),
      .rst_n     (rst_n),
      .inc       (inc),
      .load      (load),
      .load_val  (sc_q),
      .val       (sec),
      .carry_out (sec_c)
   );

   bcd_mod_counter #(.MOD(60)) u_min (
      .clk_input (clk_input),
      .rst_n     (rst_n),
      .inc       (sec_c),
      .load      (load),
      .load_val  (mn_q),
      .val       (min),
      .carry_out (min_c)
   );

   bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
      .clk_input (clk_input),
      .rst_n     (rst_n),
      .inc       (min_c),
      .load      (load),
      .load_val  (hr_q),
      .val       (hour),
      .carry_out (hour_c)
   );

   assign set_err   = set_err_q;
   assign sec_pulse = sec_pulse_q;
   assign day_wrap  = day_wrap_q;

endmodule
